// File: rtl/stage_if_pkg.sv
// ---------------------------------------------------------------------------
// stage_if_pkg
//   Shared definitions for the instruction-fetch stage and its consumers.
//   - Exception codes carried in the IF->ID bundle.
//   - Field widths/offsets of the flattened IF->ID bundle, plus pack/unpack
//     helpers so fetch and decode agree on one bit layout.
//   - Small constructors for the three bundle shapes fetch ever produces:
//     a delivered word, a bubble and an address-error fault.
// ---------------------------------------------------------------------------
package stage_if_pkg;

  // Exception codes (MIPS ExcCode numbering; NONE uses an unused code).
  localparam int                EC_W    = 5;
  localparam logic [EC_W-1:0]   EC_NONE = 5'h1f;
  localparam logic [EC_W-1:0]   EC_ADEL = 5'h04;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Flattened bundle layout: {instr, next_pc, exc_code, exc_addr}, instr MSB.
  localparam int IF2ID_EXC_ADDR_W   = 32;
  localparam int IF2ID_EXC_ADDR_LSB = 0;
  localparam int IF2ID_EXC_CODE_W   = EC_W;
  localparam int IF2ID_EXC_CODE_LSB = IF2ID_EXC_ADDR_LSB + IF2ID_EXC_ADDR_W;
  localparam int IF2ID_NEXT_PC_W    = 32;
  localparam int IF2ID_NEXT_PC_LSB  = IF2ID_EXC_CODE_LSB + IF2ID_EXC_CODE_W;
  localparam int IF2ID_INSTR_W      = 32;
  localparam int IF2ID_INSTR_LSB    = IF2ID_NEXT_PC_LSB + IF2ID_NEXT_PC_W;
  localparam int IF2ID_WIRE_WIDTH   = IF2ID_INSTR_LSB + IF2ID_INSTR_W;

  typedef struct packed {
    logic [IF2ID_INSTR_W-1:0]    instr;
    logic [IF2ID_NEXT_PC_W-1:0]  next_pc;
    logic [IF2ID_EXC_CODE_W-1:0] exc_code;
    logic [IF2ID_EXC_ADDR_W-1:0] exc_addr;
  } if2id_t;

  function automatic logic [IF2ID_WIRE_WIDTH-1:0] if2id_pack(input if2id_t b);
    logic [IF2ID_WIRE_WIDTH-1:0] w;
    w = '0;
    w[IF2ID_INSTR_LSB    +: IF2ID_INSTR_W]    = b.instr;
    w[IF2ID_NEXT_PC_LSB  +: IF2ID_NEXT_PC_W]  = b.next_pc;
    w[IF2ID_EXC_CODE_LSB +: IF2ID_EXC_CODE_W] = b.exc_code;
    w[IF2ID_EXC_ADDR_LSB +: IF2ID_EXC_ADDR_W] = b.exc_addr;
    return w;
  endfunction

  function automatic if2id_t if2id_unpack(input logic [IF2ID_WIRE_WIDTH-1:0] w);
    if2id_t b;
    b.instr    = w[IF2ID_INSTR_LSB    +: IF2ID_INSTR_W];
    b.next_pc  = w[IF2ID_NEXT_PC_LSB  +: IF2ID_NEXT_PC_W];
    b.exc_code = w[IF2ID_EXC_CODE_LSB +: IF2ID_EXC_CODE_W];
    b.exc_addr = w[IF2ID_EXC_ADDR_LSB +: IF2ID_EXC_ADDR_W];
    return b;
  endfunction

  // A fetched word handed to decode.
  function automatic if2id_t if2id_word(input logic [31:0] instr,
                                        input logic [31:0] next_pc);
    if2id_t b;
    b.instr    = instr;
    b.next_pc  = next_pc;
    b.exc_code = EC_NONE;
    b.exc_addr = '0;
    return b;
  endfunction

  // Bubble: NOP with no exception; next_pc carried over from the last bundle.
  function automatic if2id_t if2id_bubble(input logic [31:0] keep_next_pc);
    return if2id_word(NOP_INSTR, keep_next_pc);
  endfunction

  // Address-error-on-fetch marker for a misaligned PC.
  function automatic if2id_t if2id_fault(input logic [31:0] bad_pc,
                                         input logic [31:0] keep_next_pc);
    if2id_t b;
    b.instr    = NOP_INSTR;
    b.next_pc  = keep_next_pc;
    b.exc_code = EC_ADEL;
    b.exc_addr = bad_pc;
    return b;
  endfunction

endpackage

// File: rtl/stage_if.sv
// ---------------------------------------------------------------------------
// stage_if
//   Instruction-fetch stage. Holds the PC, fetches one word per instruction
//   over a req/ready memory port and presents it to decode through the
//   interstage_if2id bundle. Handles branch/exception redirects (dropping any
//   in-flight fetch) and traps misaligned fetch addresses.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   stall               hazard stall: bundle and PC hold
//   branch_valid/dest   taken branch/jump redirect
//   exc_valid/dest      exception / ERET redirect (wins over branch)
//   imem_addr/req       registered fetch request, held until imem_ready
//   imem_ready/rdata    one-cycle completion strobe and returned word
//   fetch_busy          low only when a word is available this cycle
//   interstage_if2id    {instr, next_pc, exc_code, exc_addr}
//
// A PC in FETCH with no request outstanding is in its "issue slot": the
// alignment check happens there, so a redirect costs one cycle before the
// new request goes out, while straight-line fetch keeps the request up
// back-to-back for one word per cycle.
// ---------------------------------------------------------------------------
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        branch_valid,
  input  logic [31:0]                 branch_dest,
  input  logic                        exc_valid,
  input  logic [31:0]                 exc_dest,
  output logic [31:0]                 imem_addr,
  output logic                        imem_req,
  input  logic                        imem_ready,
  input  logic [31:0]                 imem_rdata,
  output logic                        fetch_busy,
  output logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_FAULT   = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] hold_word_reg, hold_word_next;
  logic        req_reg, req_next;
  logic [31:0] addr_reg, addr_next;
  if2id_t      bundle_reg, bundle_next;

  logic [31:0] pc_inc;
  logic        redirect;
  logic [31:0] redirect_dest;
  logic        pc_misaligned;

  assign pc_inc        = pc_reg + PC_STEP;  // 32-bit modulo wrap is intended
  assign redirect      = exc_valid | branch_valid;
  assign redirect_dest = exc_valid ? exc_dest : branch_dest;
  assign pc_misaligned = (pc_reg[1:0] != 2'b00);

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    hold_word_next = hold_word_reg;
    req_next       = req_reg;
    addr_next      = addr_reg;
    bundle_next    = bundle_reg;

    if (redirect) begin
      // The delay slot was delivered earlier, so the bundle simply bubbles.
      pc_next     = redirect_dest;
      bundle_next = if2id_bubble(bundle_reg.next_pc);
      if (req_reg && !imem_ready) begin
        // Request must stay stable until the memory completes it.
        state_next = ST_DISCARD;
      end else begin
        state_next = ST_FETCH;
        req_next   = 1'b0;
      end
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (!req_reg) begin
            // Issue slot: the PC is checked here before any request leaves.
            if (pc_misaligned) begin
              if (!stall) begin
                state_next  = ST_FAULT;
                bundle_next = if2id_fault(pc_reg, bundle_reg.next_pc);
              end
            end else begin
              req_next  = 1'b1;
              addr_next = pc_reg;
              if (!stall) begin
                bundle_next = if2id_bubble(bundle_reg.next_pc);
              end
            end
          end else if (imem_ready) begin
            if (stall) begin
              hold_word_next = imem_rdata;
              state_next     = ST_HOLD;
              req_next       = 1'b0;
            end else begin
              bundle_next = if2id_word(imem_rdata, pc_inc);
              pc_next     = pc_inc;
              addr_next   = pc_inc;
            end
          end else if (!stall) begin
            bundle_next = if2id_bubble(bundle_reg.next_pc);
          end
        end

        ST_HOLD: begin
          if (!stall) begin
            // pc was aligned when its word was fetched, so pc+4 is too and
            // the next request can go out without another issue slot.
            bundle_next = if2id_word(hold_word_reg, pc_inc);
            pc_next     = pc_inc;
            addr_next   = pc_inc;
            req_next    = 1'b1;
            state_next  = ST_FETCH;
          end
        end

        ST_DISCARD: begin
          if (!stall) begin
            bundle_next = if2id_bubble(bundle_reg.next_pc);
          end
          if (imem_ready) begin
            // Stale word dropped; the redirected pc issues next cycle.
            req_next   = 1'b0;
            state_next = ST_FETCH;
          end
        end

        default: begin
          // ST_FAULT: parked until a redirect or reset.
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FETCH;
      pc_reg        <= RESET_PC;
      hold_word_reg <= '0;
      req_reg       <= 1'b0;
      addr_reg      <= RESET_PC;
      bundle_reg    <= if2id_bubble(RESET_PC);
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      hold_word_reg <= hold_word_next;
      req_reg       <= req_next;
      addr_reg      <= addr_next;
      bundle_reg    <= bundle_next;
    end
  end

  assign imem_addr        = addr_reg;
  assign imem_req         = req_reg;
  assign interstage_if2id = if2id_pack(bundle_reg);

  // A word is available when memory completes a live request or one is held.
  assign fetch_busy = !(((state_reg == ST_FETCH) && req_reg && imem_ready) ||
                        (state_reg == ST_HOLD));

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

  localparam logic [4:0]  EC_NONE  = 5'h1f;
  localparam logic [4:0]  EC_ADEL  = 5'h04;
  localparam logic [31:0] RST_PC   = 32'hbfc00000;

  logic         clk = 1'b0;
  logic         rst, stall, branch_valid, exc_valid, imem_ready, imem_req, fetch_busy;
  logic [31:0]  branch_dest, exc_dest, imem_rdata, imem_addr;
  logic [100:0] bus;

  int n_vec = 0;
  int n_bad = 0;

  stage_if #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_valid(branch_valid), .branch_dest(branch_dest),
    .exc_valid(exc_valid), .exc_dest(exc_dest),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .fetch_busy(fetch_busy), .interstage_if2id(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Bundle field views (layout instr | next_pc | exc_code | exc_addr).
  logic [31:0] b_instr, b_npc, b_eaddr;
  logic [4:0]  b_ec;
  assign b_instr = bus[100:69];
  assign b_npc   = bus[68:37];
  assign b_ec    = bus[36:32];
  assign b_eaddr = bus[31:0];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'h1357_9bdf) * 32'h9e37_79b1) | 32'h1;
  endfunction

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] bd;
    logic        exc;
    logic [31:0] ed;
    logic        rdy;
    logic [31:0] rdata;
    int          busy;     // 0/1 expected, 2 = not checked
    logic        req;
    logic [31:0] addr, instr, npc;
    logic [4:0]  ec;
    logic [31:0] ea;
  } vec_t;

  function automatic vec_t row(input logic r, input logic s, input logic b, input logic [31:0] bd,
                               input logic e, input logic [31:0] ed, input logic rdy, input logic [31:0] rd,
                               input int busy, input logic req, input logic [31:0] addr,
                               input logic [31:0] instr, input logic [31:0] npc,
                               input logic [4:0] ec, input logic [31:0] ea);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.bd = bd; v.exc = e; v.ed = ed; v.rdy = rdy; v.rdata = rd;
    v.busy = busy; v.req = req; v.addr = addr; v.instr = instr; v.npc = npc; v.ec = ec; v.ea = ea;
    return v;
  endfunction

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    rst = v.rst; stall = v.stall;
    branch_valid = v.br; branch_dest = v.bd;
    exc_valid = v.exc; exc_dest = v.ed;
    imem_ready = v.rdy; imem_rdata = v.rdy ? v.rdata : $urandom;
    #1;
    if (v.busy != 2) check({tag, ".busy"}, 128'(fetch_busy), 128'(v.busy[0]));
    @(posedge clk); #1;
    check({tag, ".req"},  128'(imem_req), 128'(v.req));
    check({tag, ".addr"}, 128'(imem_addr), 128'(v.addr));
    check({tag, ".bundle"}, 128'({b_instr, b_npc, b_ec, b_eaddr}),
          128'({v.instr, v.npc, v.ec, v.ea}));
  endtask

  vec_t vecs[$];

  // random-phase state
  int          wait_cnt, idle, delivered;
  logic [31:0] out_addr, exp_addr;
  logic [100:0] prev_bus;
  logic        busy_pre, r_br, r_exc;

  initial begin
    rst = 1'b1; stall = 0; branch_valid = 0; exc_valid = 0; imem_ready = 0;
    branch_dest = 0; exc_dest = 0; imem_rdata = 0;

    // r s b bd e ed rdy rdata | busy req addr instr npc ec ea
    vecs.push_back(row(1,0,0,0,0,0,0,0,                  2,0,RST_PC,       0,            RST_PC,       EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,RST_PC,       0,            RST_PC,       EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h24020005,       0,1,32'hbfc00004, 32'h24020005, 32'hbfc00004, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h11111111,       0,1,32'hbfc00008, 32'h11111111, 32'hbfc00008, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,32'hbfc00008, 0,            32'hbfc00008, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,32'hbfc00008, 0,            32'hbfc00008, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h22222222,       0,1,32'hbfc0000c, 32'h22222222, 32'hbfc0000c, EC_NONE,0));
    vecs.push_back(row(0,1,0,0,0,0,1,32'h33333333,       0,0,32'hbfc0000c, 32'h22222222, 32'hbfc0000c, EC_NONE,0));
    vecs.push_back(row(0,1,0,0,0,0,0,0,                  0,0,32'hbfc0000c, 32'h22222222, 32'hbfc0000c, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  0,1,32'hbfc00010, 32'h33333333, 32'hbfc00010, EC_NONE,0));
    vecs.push_back(row(0,0,1,32'h80000100,0,0,0,0,       1,1,32'hbfc00010, 0,            32'hbfc00010, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,32'hbfc00010, 0,            32'hbfc00010, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h44444444,       1,0,32'hbfc00010, 0,            32'hbfc00010, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,32'h80000100, 0,            32'hbfc00010, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h55555555,       0,1,32'h80000104, 32'h55555555, 32'h80000104, EC_NONE,0));
    vecs.push_back(row(0,0,1,32'h80000102,0,0,1,32'h66666666, 2,0,32'h80000104, 0,       32'h80000104, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,0,32'h80000104, 0,            32'h80000104, EC_ADEL,32'h80000102));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,0,32'h80000104, 0,            32'h80000104, EC_ADEL,32'h80000102));
    vecs.push_back(row(0,0,1,32'h80000200,1,32'h80000180,0,0, 1,0,32'h80000104, 0,       32'h80000104, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,32'h80000180, 0,            32'h80000104, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h77777777,       0,1,32'h80000184, 32'h77777777, 32'h80000184, EC_NONE,0));
    vecs.push_back(row(0,0,1,32'h80000300,0,0,0,0,       1,1,32'h80000184, 0,            32'h80000184, EC_NONE,0));
    vecs.push_back(row(1,0,0,0,0,0,0,0,                  2,0,RST_PC,       0,            RST_PC,       EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,RST_PC,       0,            RST_PC,       EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h24020005,       0,1,32'hbfc00004, 32'h24020005, 32'hbfc00004, EC_NONE,0));
    vecs.push_back(row(0,0,1,32'hfffffffc,0,0,1,32'h88888888, 2,0,32'hbfc00004, 0,       32'hbfc00004, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,0,0,                  1,1,32'hfffffffc, 0,            32'hbfc00004, EC_NONE,0));
    vecs.push_back(row(0,0,0,0,0,0,1,32'h99999999,       0,1,32'h00000000, 32'h99999999, 32'h00000000, EC_NONE,0));

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("v%0d", i), vecs[i]);

    // Hand-written: word buffered during stall, then a redirect drops it.
    apply("hold.buffer",   row(0,1,0,0,0,0,1,32'haaaaaaaa, 0,0,32'h00000000, 32'h99999999, 32'h00000000, EC_NONE,0));
    apply("hold.redirect", row(0,1,1,32'h80000400,0,0,0,0, 0,0,32'h00000000, 0,            32'h00000000, EC_NONE,0));
    apply("hold.issue",    row(0,0,0,0,0,0,0,0,          1,1,32'h80000400, 0,            32'h00000000, EC_NONE,0));
    apply("hold.deliver",  row(0,0,0,0,0,0,1,32'hbbbbbbbb, 0,1,32'h80000404, 32'hbbbbbbbb, 32'h80000404, EC_NONE,0));

    // Randomized run against a fetch-stream model: delivered words must be
    // mem_word() of consecutive addresses starting at the last redirect.
    @(negedge clk);
    rst = 1'b1; stall = 0; branch_valid = 0; exc_valid = 0; imem_ready = 0;
    @(negedge clk);
    rst = 1'b0;
    wait_cnt = -1; idle = 0; exp_addr = RST_PC; out_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // memory model (runs at negedge, drives ready for the coming edge)
      if (imem_ready) wait_cnt = -1;
      else if (wait_cnt >= 0) begin
        check("rnd.req_held", 128'(imem_req), 128'(1));
        check("rnd.addr_held", 128'(imem_addr), 128'(out_addr));
      end
      if (!imem_req) begin
        imem_ready = 0; wait_cnt = -1; imem_rdata = $urandom;
      end else begin
        if (wait_cnt < 0) begin
          wait_cnt = $urandom_range(0, 3);
          out_addr = imem_addr;
        end
        if (wait_cnt == 0) begin
          imem_ready = 1; imem_rdata = mem_word(imem_addr);
        end else begin
          imem_ready = 0; imem_rdata = $urandom; wait_cnt--;
        end
      end
      stall        = ($urandom_range(0, 2) == 0);
      r_br         = ($urandom_range(0, 15) == 0);
      r_exc        = ($urandom_range(0, 39) == 0);
      branch_valid = r_br;
      exc_valid    = r_exc;
      branch_dest  = {16'h8000, 14'($urandom), 2'b00};
      exc_dest     = {16'h8001, 14'($urandom), 2'b00};
      prev_bus     = bus;
      #1;
      busy_pre = fetch_busy;
      @(posedge clk); #1;
      if (r_br || r_exc) begin
        exp_addr = r_exc ? exc_dest : branch_dest;
        check("rnd.redirect_bubble", 128'(bus), 128'({32'h0, prev_bus[68:37], EC_NONE, 32'h0}));
        idle = 0;
      end else if (stall) begin
        check("rnd.stall_hold", 128'(bus), 128'(prev_bus));
      end else begin
        delivered = (b_instr != 0) ? 1 : 0;
        check("rnd.busy", 128'(busy_pre), 128'(delivered == 0));
        if (delivered != 0) begin
          check("rnd.word", 128'(bus), 128'({mem_word(exp_addr), exp_addr + 32'd4, EC_NONE, 32'h0}));
          exp_addr = exp_addr + 32'd4;
          idle = 0;
        end else begin
          check("rnd.bubble", 128'(bus), 128'({32'h0, prev_bus[68:37], EC_NONE, 32'h0}));
          idle++;
          check("rnd.progress", 128'(idle > 40), 128'(0));
          if (idle > 40) idle = 0;
        end
      end
      @(negedge clk);
      branch_valid = 0; exc_valid = 0;
      // Drop back to the negedge-aligned loop top without losing a cycle.
      #0;
      if (cyc < 2999) begin
        // Re-enter: the loop body expects to start at a negedge.
      end
      // Next iteration continues at this negedge; undo the extra wait by
      // not waiting again at loop top.
      if (1'b0) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stage_if.md
# stage_if

Instruction-fetch stage: holds the PC, fetches one word per instruction over a request/ready instruction-memory port and hands the fetched word to the decode stage through the `interstage_if2id` bundle. It redirects the PC on branch and exception requests and discards any fetch that is in flight when a redirect arrives. It traps misaligned fetch addresses. It sits directly upstream of the decode stage and consumes the decode/EX-resolved branch target and the CP0 exception vector.

## Interface
Parameters:
- `RESET_PC`, 32'hbfc00000: PC loaded on reset.

Ports:
- `clk`  in  1  sole clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard stall; IF→ID bundle and PC hold.
- `branch_valid`  in  1  taken branch or jump; redirect PC.
- `branch_dest`  in  32  branch target.
- `exc_valid`  in  1  exception or ERET redirect.
- `exc_dest`  in  32  exception vector or EPC.
- `imem_addr`  out  32  fetch address; equals `pc` while `imem_req` is high.
- `imem_req`  out  1  fetch request; held until `imem_ready` is sampled high.
- `imem_ready`  in  1  one-cycle completion strobe; may be asserted in the same cycle as `imem_req`.
- `imem_rdata`  in  32  word; valid only when `imem_ready` is high.
- `fetch_busy`  out  1  high when no new word was delivered this cycle; goes to the hazard unit.
- `interstage_if2id`  out  `IF2ID_WIRE_WIDTH`  bundle `{instr[31:0], next_pc[31:0], exc_code, exc_addr[31:0]}`.

## Operation
- Registers:
  - `pc`: address of the word being fetched.
  - `hold_word`: one-entry buffer for a word that arrives while stalled.
  - Bundle fields: `instr`, `next_pc`, `exc_code`, `exc_addr`.
- States:
  - FETCH: request outstanding for `pc`.
  - HOLD: word buffered while stalled; no request.
  - DISCARD: redirected while a request was outstanding; waiting for `imem_ready` and dropping the word.
  - FAULT: misaligned `pc`; no request.
- Priority each cycle: `rst` > `exc_valid` > `branch_valid` > `stall` > normal.
- Reset:
  - `pc`=`RESET_PC`, state FETCH.
  - Bundle: `instr`=0 (NOP), `next_pc`=`RESET_PC`, `exc_code`=`EC_NONE`, `exc_addr`=0.
  - `imem_req`=0 in the reset cycle; `fetch_busy`=1.
- FETCH with `imem_ready` and not `stall`:
  - Bundle gets `instr`=`imem_rdata`, `next_pc`=`pc`+4, `exc_code`=`EC_NONE`.
  - `pc`<=`pc`+4; stay in FETCH.
- FETCH with `imem_ready` and `stall`: `hold_word`<=`imem_rdata`, go to HOLD; bundle unchanged.
- HOLD with not `stall`: deliver `hold_word` exactly as above, `pc`<=`pc`+4, go to FETCH.
- FETCH without `imem_ready` and not `stall`: bundle becomes a bubble (`instr`=0, `exc_code`=`EC_NONE`, `next_pc` unchanged); `fetch_busy`=1.
- Redirect (`exc_valid` or `branch_valid`):
  - `pc`<=dest; bundle becomes a bubble (the delay slot has already been delivered by then).
  - If `imem_req` is high and `imem_ready` is low, go to DISCARD; otherwise go to FETCH.
  - A redirect in HOLD drops `hold_word`. A redirect overrides `stall`.
  - The new `pc` is checked for alignment before issue.
- DISCARD: `imem_req` stays high at the old address until `imem_ready`. The word is dropped and the next cycle issues `pc`. A second redirect in DISCARD only updates `pc`.
- Misalignment (`pc[1:0]`≠0 on entry to FETCH):
  - No request issued.
  - Bundle gets `exc_code`=`EC_ADEL`, `exc_addr`=`pc`, `instr`=0; go to FAULT.
  - FAULT leaves only on a redirect or reset.
- PC arithmetic is 32-bit modulo; 32'hfffffffc+4 wraps to 0 without error.

## Timing
- Fetch-to-decode latency: the word is in the bundle on the posedge that samples `imem_ready`. With zero-wait memory the throughput is one instruction per cycle.
- `imem_addr`/`imem_req` are registered outputs; they never change while a request is outstanding, except on reset.
- `fetch_busy` is combinational from state and `imem_ready`.
- The bundle changes only when `stall` is low, or on a redirect, or on reset.
- A reset mid-request abandons the request. The memory is expected to treat a deasserted `imem_req` as a cancel.

## Structure
- `EC_*` codes (including `EC_ADEL`) go in `common.vh`.
- `IF2ID_*` field widths and offsets are generated into `gencode/if2id_param.v`, with pack/unpack includes shared with decode.
- State encodings are localparams.
- No sub-module is needed; the PC incrementer and the state machine stay inline.

## Test plan
- Reset, then zero-wait memory returning 32'h24020005 at 32'hbfc00000: the bundle shows that `instr` with `next_pc`=32'hbfc00004 on the first `imem_ready` edge; `imem_addr` advances to 32'hbfc00004.
- `imem_ready` 3 cycles after request: 2 bubble cycles with `fetch_busy`=1, then the word appears; `pc` does not skip.
- `stall` high when `imem_ready` arrives: the bundle holds its old value; the word is delivered on the first cycle `stall` drops; no extra request is issued during the stall.
- `branch_valid` with dest 32'h80000100 while a request is outstanding: the late word is dropped, the next request goes to 32'h80000100, and no stale `instr` reaches the bundle.
- `branch_dest`=32'h80000102: no request; the bundle shows `EC_ADEL` with `exc_addr`=32'h80000102; FAULT holds until `exc_valid` with `exc_dest` 32'h80000180 resumes fetching there.
- `exc_valid` and `branch_valid` asserted in the same cycle: `pc` takes `exc_dest`; `rst` asserted in DISCARD returns to `RESET_PC` with a NOP bundle.
